// File: rtl/alu_seq.sv
// Execute-stage ALU: single-cycle move/add/sub/and/shift ops plus an iterative
// shift-add multiplier (MUL/MULH), valid/ready on both sides, registered result and flags.
module alu_seq #(
  parameter  int REG_WIDTH = 16,
  localparam int SCNT_W    = $clog2(REG_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] ra,
  input  logic [REG_WIDTH-1:0] rb,
  input  logic [REG_WIDTH-1:0] imm,
  input  logic                 op2sel,
  input  logic                 flagcin,
  input  logic [3:0]           aluopc,
  input  logic [1:0]           shiftopc,
  input  logic [SCNT_W-1:0]    scnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_WIDTH-1:0] out,
  output logic                 flagc,
  output logic                 flagv,
  output logic                 flagz,
  output logic                 flagn
);
  localparam int W = REG_WIDTH;

  localparam logic [3:0] OP_ADD = 4'd1, OP_ADC = 4'd2, OP_SUB = 4'd3, OP_SBC = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5, OP_RSB = 4'd6, OP_SHF = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8, OP_MULH = 4'd9;

  typedef enum logic {IDLE, MUL} state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_q, out_d;
  logic              c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
  logic [SCNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]      mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2*W-1:0]    acc_q, acc_d;
  logic              mulh_q, mulh_d;

  // Single-cycle datapath
  logic [W-1:0]      opb, add_a, add_b;
  logic              add_ci, add_v;
  logic [W:0]        add_sum;
  logic [W:0]        lsl_ext, lsr_ext, asr_ext;
  logic [W-1:0]      ror_res;
  logic [SCNT_W-1:0] rot_l;
  logic [W-1:0]      sc_res;
  logic              sc_c, sc_v;
  logic              is_mul, accept;

  assign opb = op2sel ? imm : rb;

  always_comb begin
    add_a  = ra;
    add_b  = opb;
    add_ci = 1'b0;
    case (aluopc)
      OP_ADC: add_ci = flagcin;
      OP_SUB: begin add_b = ~opb; add_ci = 1'b1;    end
      OP_SBC: begin add_b = ~opb; add_ci = flagcin; end
      OP_RSB: begin add_a = opb;  add_b = ~ra; add_ci = 1'b1; end
      default: ;
    endcase
  end

  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};
  assign add_v   = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);

  // Extended shifts keep the last bit shifted out in the spare position.
  assign lsl_ext = {1'b0, rb} << scnt;
  assign lsr_ext = {rb, 1'b0} >> scnt;
  assign asr_ext = $signed({rb, 1'b0}) >>> scnt;
  assign rot_l   = ~scnt + SCNT_W'(1);
  assign ror_res = (rb >> scnt) | (rb << rot_l);

  always_comb begin
    sc_res = opb;
    sc_c   = flagcin;
    sc_v   = 1'b0;
    case (aluopc)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB: begin
        sc_res = add_sum[W-1:0];
        sc_c   = add_sum[W];
        sc_v   = add_v;
      end
      OP_AND: sc_res = ra & opb;
      OP_SHF: begin
        if (scnt == '0) begin
          sc_res = rb;
        end else begin
          case (shiftopc)
            2'd0:    begin sc_res = lsl_ext[W-1:0]; sc_c = lsl_ext[W]; end
            2'd1:    begin sc_res = lsr_ext[W:1];   sc_c = lsr_ext[0]; end
            2'd2:    begin sc_res = asr_ext[W:1];   sc_c = asr_ext[0]; end
            default: begin sc_res = ror_res;        sc_c = ror_res[W-1]; end
          endcase
        end
      end
      default: ;
    endcase
  end

  assign is_mul   = (aluopc == OP_MUL) || (aluopc == OP_MULH);
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Multiplier: one partial product per cycle, final one folded into the result load.
  logic [2*W-1:0] acc_nxt;
  assign acc_nxt = acc_q + (mplier_q[cnt_q] ? ({{W{1'b0}}, mcand_q} << cnt_q) : '0);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    c_d         = c_q;
    v_d         = v_q;
    z_d         = z_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    mulh_d      = mulh_q;
    case (state_q)
      IDLE: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
          if (is_mul) begin
            state_d     = MUL;
            mcand_d     = ra;
            mplier_d    = opb;
            acc_d       = '0;
            cnt_d       = '0;
            mulh_d      = (aluopc == OP_MULH);
            out_valid_d = 1'b0;
          end else begin
            out_d       = sc_res;
            c_d         = sc_c;
            v_d         = sc_v;
            z_d         = (sc_res == '0);
            n_d         = sc_res[W-1];
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + SCNT_W'(1);
        if (cnt_q == SCNT_W'(W-1)) begin
          state_d     = IDLE;
          cnt_d       = '0;
          out_d       = mulh_q ? acc_nxt[2*W-1:W] : acc_nxt[W-1:0];
          c_d         = mulh_q ? 1'b0 : (acc_nxt[2*W-1:W] != '0);
          v_d         = 1'b0;
          z_d         = mulh_q ? (acc_nxt[2*W-1:W] == '0) : (acc_nxt[W-1:0] == '0);
          n_d         = mulh_q ? acc_nxt[2*W-1] : acc_nxt[W-1];
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      mulh_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      c_q         <= c_d;
      v_q         <= v_d;
      z_q         <= z_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      mulh_q      <= mulh_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign flagc     = c_q;
  assign flagv     = v_q;
  assign flagz     = z_q;
  assign flagn     = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (REG_WIDTH=16); expected results are hand-computed.
module tb_alu_seq;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  ra, rb, imm;
  logic          op2sel, flagcin;
  logic [3:0]    aluopc;
  logic [1:0]    shiftopc;
  logic [3:0]    scnt;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_w;
  logic          flagc, flagv, flagz, flagn;

  int n_chk  = 0;
  int n_pass = 0;

  alu_seq #(.REG_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .ra(ra), .rb(rb), .imm(imm), .op2sel(op2sel), .flagcin(flagcin),
    .aluopc(aluopc), .shiftopc(shiftopc), .scnt(scnt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out_w), .flagc(flagc), .flagv(flagv), .flagz(flagz), .flagn(flagn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [3:0] fl();
    return {flagc, flagv, flagz, flagn};
  endfunction

  task automatic set_in(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] im, input logic sel, input logic cin,
                        input logic [1:0] sh, input logic [3:0] sc);
    aluopc = op; ra = a; rb = b; imm = im; op2sel = sel; flagcin = cin;
    shiftopc = sh; scnt = sc;
  endtask

  // Present one op for a single edge; returns #1 after the accepting edge.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] im, input logic sel,
                       input logic cin, input logic [1:0] sh, input logic [3:0] sc);
    @(negedge clk);
    set_in(op, a, b, im, sel, cin, sh, sc);
    in_valid = 1'b1;
    #1 chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] e_out, input logic [3:0] e_fl);
    chk({tag, ".vld"}, 32'(out_valid), 32'd1);
    chk({tag, ".out"}, 32'(out_w), 32'(e_out));
    chk({tag, ".cvzn"}, 32'(fl()), 32'(e_fl));
  endtask

  task automatic run_mul(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] e_out, input logic [3:0] e_fl);
    int bad;
    bad = 0;
    do_op(tag, op, a, b, 16'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    // Garbage held on the input port while the multiplier is busy must be ignored.
    set_in(4'd1, 16'h1111, 16'h2222, 16'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    in_valid = 1'b1;
    if (out_valid || in_ready) bad++;
    for (int k = 1; k < W; k++) begin
      @(posedge clk);
      #1 if (out_valid || in_ready) bad++;
    end
    chk({tag, ".busy"}, 32'(bad), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk_res(tag, e_out, e_fl);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_in(4'd0, '0, '0, '0, 1'b0, 1'b0, 2'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.vld", 32'(out_valid), 32'd0);
    chk("rst.out", 32'(out_w), 32'd0);
    chk("rst.cvzn", 32'(fl()), 32'd0);
    chk("rst.rdy", 32'(in_ready), 32'd1);
    @(negedge clk) rst = 1'b0;

    // Single-cycle ops; flags packed as {C,V,Z,N}
    do_op("add", 4'd1, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    chk_res("add", 16'h8000, 4'b0101);
    do_op("sub", 4'd3, 16'h0005, 16'h0, 16'h0005, 1'b1, 1'b0, 2'd0, 4'd0);
    chk_res("sub", 16'h0000, 4'b1010);
    do_op("asr", 4'd7, 16'h0, 16'h8001, 16'h0, 1'b0, 1'b0, 2'd2, 4'd1);
    chk_res("asr", 16'hC000, 4'b1001);
    do_op("ror", 4'd7, 16'h0, 16'h1234, 16'h0, 1'b0, 1'b0, 2'd3, 4'd4);
    chk_res("ror", 16'h4123, 4'b0000);
    do_op("shf0", 4'd7, 16'h0, 16'h1234, 16'h0, 1'b0, 1'b1, 2'd1, 4'd0);
    chk_res("shf0", 16'h1234, 4'b1000);
    do_op("lsl", 4'd7, 16'h0, 16'h8001, 16'h0, 1'b0, 1'b0, 2'd0, 4'd1);
    chk_res("lsl", 16'h0002, 4'b1000);
    do_op("lsr", 4'd7, 16'h0, 16'h0003, 16'h0, 1'b0, 1'b0, 2'd1, 4'd1);
    chk_res("lsr", 16'h0001, 4'b1000);
    do_op("adc", 4'd2, 16'hFFFF, 16'h5555, 16'h0000, 1'b1, 1'b1, 2'd0, 4'd0);
    chk_res("adc", 16'h0000, 4'b1010);
    do_op("sbc", 4'd4, 16'h0003, 16'h0005, 16'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    chk_res("sbc", 16'hFFFD, 4'b0001);
    do_op("rsb", 4'd6, 16'h0002, 16'h0007, 16'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    chk_res("rsb", 16'h0005, 4'b1000);
    do_op("and", 4'd5, 16'hF0F0, 16'h0FF0, 16'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    chk_res("and", 16'h00F0, 4'b0000);
    do_op("mov", 4'd0, 16'h1234, 16'h0, 16'h8000, 1'b1, 1'b1, 2'd0, 4'd0);
    chk_res("mov", 16'h8000, 4'b1001);
    do_op("rsvd", 4'd12, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 2'd0, 4'd0);
    chk_res("rsvd", 16'h0000, 4'b0010);

    // Multiplier
    run_mul("mul", 4'd8, 16'h0100, 16'h0100, 16'h0000, 4'b1010);
    run_mul("mulh", 4'd9, 16'hFFFF, 16'hFFFF, 16'hFFFE, 4'b0001);
    run_mul("mulff", 4'd8, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b1000);

    // Backpressure: drain, then stall a result for 5 cycles with a new op waiting
    @(posedge clk);
    #1 chk("drain.vld", 32'(out_valid), 32'd0);
    @(negedge clk) out_ready = 1'b0;
    do_op("bp", 4'd1, 16'h0001, 16'h0002, 16'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    set_in(4'd3, 16'h000A, 16'h0004, 16'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk_res("bp.hold", 16'h0003, 4'b0000);
      chk("bp.rdy", 32'(in_ready), 32'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    #1 chk("bp.rdy1", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk_res("bp.swap", 16'h0006, 4'b1000);
    @(posedge clk);
    #1 chk("bp.pop", 32'(out_valid), 32'd0);

    // Reset during MUL iteration 7
    do_op("mrst", 4'd8, 16'h0003, 16'h0005, 16'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    repeat (7) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mrst.vld", 32'(out_valid), 32'd0);
    chk("mrst.rdy", 32'(in_ready), 32'd1);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mrst.quiet", 32'(out_valid), 32'd0);
    chk("mrst.rdy2", 32'(in_ready), 32'd1);
    do_op("add2", 4'd1, 16'h0002, 16'h0003, 16'h0, 1'b0, 1'b0, 2'd0, 4'd0);
    chk_res("add2", 16'h0005, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
